sync_fifo_ctl: RTL and testbench
================================

Name: sync_fifo_ctl

Overview:
Single-clock, parametrised successor to the existing dual-clock FIFO, for buffering within one clock domain (datapath staging, command queues). Adds:
- occupancy count
- programmable almost-full / almost-empty flags
- selectable show-ahead (FWFT) or registered-read mode
- synchronous flush
- sticky overflow/underflow error flags

Storage is a 2^ASIZE-entry register array; pointers are ASIZE+1 bits with a wrap bit.

Parameters:
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; DEPTH = 1<<ASIZE entries.
- AFULL_TH, 12: almost_full asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.
- FWFT, 1: 1 = show-ahead read; 0 = registered read with 1-cycle latency.

Ports:
- clk, input, 1: sole clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- clr, input, 1: synchronous flush.
- wdata, input, DSIZE: write data.
- winc, input, 1: write request.
- rinc, input, 1: read request.
- rdata, output, DSIZE: read data.
- wfull, output, 1: FIFO full.
- rempty, output, 1: FIFO empty.
- almost_full, output, 1: count >= AFULL_TH.
- almost_empty, output, 1: count <= AEMPTY_TH.
- count, output, ASIZE+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; set on a write while full.
- underflow, output, 1: sticky; set on a read while empty.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low: clk and rst_n, with rst_n asserting asynchronously and deasserting synchronously externally.
- Reset values:
  - wptr = rptr = 0, count = 0.
  - rempty = 1, wfull = 0, almost_empty = 1, almost_full = 0 (AFULL_TH >= 1).
  - overflow = underflow = 0; rdata = 0 in FWFT=0 mode.
  - Memory array is not reset.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = winc && !wfull.
  - rd_ok = rinc && !rempty.
  - A write at full is dropped even if rinc is also high. No pass-through at full or empty.
- wr_ok: mem[wptr[ASIZE-1:0]] <= wdata; wptr <= wptr+1 (modulo 2^(ASIZE+1)).
- rd_ok: rptr <= rptr+1.
- Count update:
  - wr_ok only: count+1.
  - rd_ok only: count-1.
  - Both or neither: unchanged.
  - count is a register and must always equal wptr-rptr (ASIZE+1-bit subtraction); a verification assertion checks this.
- Flags: decoded combinationally from registered count.
  - wfull = (count==DEPTH); rempty = (count==0).
  - almost_full / almost_empty per their thresholds.
  - All flags update in the cycle after the causing edge.
- Read data, FWFT=1: rdata = mem[rptr[ASIZE-1:0]] combinationally. The head is valid whenever !rempty; rdata is undefined when empty.
- Read data, FWFT=0:
  - rdata is registered: on rd_ok, rdata <= mem[rptr] (value visible the cycle after rinc).
  - Otherwise rdata holds its value, including across underflow attempts.
- Error flags:
  - overflow <= 1 when winc && wfull.
  - underflow <= 1 when rinc && rempty.
  - Both are sticky until clr or reset.
- clr:
  - Next edge: wptr = rptr = count = 0; overflow = underflow = 0; FWFT=0 rdata <= 0.
  - Overrides winc/rinc in the same cycle; no write or read is performed.
  - Memory contents are untouched.
- Wrap-around: pointers wrap naturally. Full when address bits are equal and wrap bits differ; this must agree with count==DEPTH.
- Reset mid-operation: all state returns immediately to reset values; in-flight data is discarded.
- Elaboration checks: parameter violations (AFULL_TH or AEMPTY_TH out of range, ASIZE < 1) are flagged with $error.

Decomposition:
- Package fifo_pkg:
  - function clog2-free DEPTH helper (1<<ASIZE)
  - typedef for pointer/count width parameterised via localparams in the module
  - shared constants for FWFT/REG read-mode encoding, reused by future FIFO variants
- Sub-module fifo_mem:
  - DSIZE x 2^ASIZE register array
  - one synchronous write port (wen, waddr, wdata)
  - one asynchronous read port (raddr -> rdata)
  - sync_fifo_ctl instantiates it and adds the FWFT=0 output register outside it.

Test Plan:
All scenarios use DSIZE=8, ASIZE=4, AFULL_TH=12, AEMPTY_TH=2.
1. Reset, then write 0x00..0x0F in 16 consecutive cycles:
   - count steps 1..16.
   - almost_empty deasserts when count = 3.
   - almost_full asserts at count = 12.
   - wfull asserts after the 16th write.
   - 17th winc (0xAA) is dropped; overflow = 1; count stays 16.
2. From full, read 16 times, FWFT=1: rdata sequence 0x00..0x0F; rempty = 1 after the last read. Next rinc sets underflow = 1 and leaves count = 0.
3. FWFT=0 build: write 0x5A, 0x3C; rinc one cycle:
   - rdata = 0x5A on the following cycle and holds while rinc is low.
   - Second rinc gives 0x3C.
   - Third rinc (empty): rdata stays 0x3C; underflow = 1.
4. Simultaneous winc+rinc for 40 cycles at count = 5 with an incrementing pattern: count stays 5; reads return data in order across two pointer wraps; wptr-rptr == count every cycle.
5. clr at count = 9 with winc = rinc = 1 and overflow set:
   - Next cycle count = 0, rempty = 1, overflow = 0.
   - No write occurs.
   - Subsequent write 0x77 is read back first.
6. Assert rst_n low asynchronously mid-burst at count = 7 (between edges): outputs reach reset values before the next clk edge. After release, write/read of 0x11 works normally.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode encoding and
// depth helper so that every variant sizes its storage the same way.
package fifo_pkg;

    typedef enum logic {
        READ_MODE_REG  = 1'b0,
        READ_MODE_FWFT = 1'b1
    } read_mode_e;

    function automatic int fifoDepth(input int aSize);
        return 1 << aSize;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port and one asynchronous read
// port, so the controller decides whether the read path is registered.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifoDepth(ASIZE);

    logic [DSIZE-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; occupancy tracking makes stale data unreachable.
    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with occupancy count, threshold flags, sticky
// error flags, synchronous flush and a selectable show-ahead or registered read.
module sync_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = fifoDepth(ASIZE);

    typedef logic [ASIZE:0] ptr_t;

    generate
        if (ASIZE < 1) begin : g_badAsize
            $error("sync_fifo_ctl: ASIZE must be at least 1");
        end
        if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_badAfull
            $error("sync_fifo_ctl: AFULL_TH must lie in 1..DEPTH");
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_badAempty
            $error("sync_fifo_ctl: AEMPTY_TH must lie in 0..DEPTH-1");
        end
    endgenerate

    ptr_t             r_wPtr;
    ptr_t             r_rPtr;
    ptr_t             r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wrOk;
    logic             w_rdOk;
    logic             w_full;
    logic             w_empty;
    logic [DSIZE-1:0] w_memRdata;

    assign w_full  = (r_count == ptr_t'(DEPTH));
    assign w_empty = (r_count == '0);

    // Flush wins over both requests; full/empty block the request even if the other side is active.
    assign w_wrOk = winc && !w_full  && !clr;
    assign w_rdOk = rinc && !w_empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wPtr      <= '0;
            r_rPtr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wPtr      <= '0;
            r_rPtr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrOk) begin
                r_wPtr <= r_wPtr + 1'b1;
            end
            if (w_rdOk) begin
                r_rPtr <= r_rPtr + 1'b1;
            end
            case ({w_wrOk, w_rdOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .wen   (w_wrOk),
        .waddr (r_wPtr[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (r_rPtr[ASIZE-1:0]),
        .rdata (w_memRdata)
    );

    generate
        if (FWFT == int'(READ_MODE_FWFT)) begin : g_fwft
            assign rdata = w_memRdata;
        end else begin : g_regRead
            logic [DSIZE-1:0] r_rdata;

            // Holds the last accepted word, including across reads attempted while empty.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (clr) begin
                    r_rdata <= '0;
                end else if (w_rdOk) begin
                    r_rdata <= w_memRdata;
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

    assign wfull        = w_full;
    assign rempty       = w_empty;
    assign almost_full  = (r_count >= ptr_t'(AFULL_TH));
    assign almost_empty = (r_count <= ptr_t'(AEMPTY_TH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // The count register is redundant with the pointers; these keep the two views honest.
    assert property (@(posedge clk) disable iff (!rst_n)
        r_count == ptr_t'(r_wPtr - r_rPtr));

    assert property (@(posedge clk) disable iff (!rst_n)
        w_full == ((r_wPtr[ASIZE] != r_rPtr[ASIZE]) &&
                   (r_wPtr[ASIZE-1:0] == r_rPtr[ASIZE-1:0])));

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives a show-ahead and a registered-read FIFO with identical stimulus and
// scores both against a queue-based reference model.
module tb_sync_fifo_ctl;

    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 12;
    localparam int AEMPTY_TH = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic       winc  = 1'b0;
    logic       rinc  = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdataF, rdataR;
    logic       wfullF, wfullR, remptyF, remptyR;
    logic       afF, afR, aeF, aeR, ovfF, ovfR, udfF, udfR;
    logic [4:0] countF, countR;

    sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(1)) dutFwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdataF), .wfull(wfullF), .rempty(remptyF), .almost_full(afF),
        .almost_empty(aeF), .count(countF), .overflow(ovfF), .underflow(udfF)
    );

    sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(0)) dutReg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdataR), .wfull(wfullR), .rempty(remptyR), .almost_full(afR),
        .almost_empty(aeR), .count(countR), .overflow(ovfR), .underflow(udfR)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] modelQ[$];
    logic [7:0] expRegQ[$];
    logic [7:0] lastRead     = 8'h00;
    logic [7:0] popped;
    bit         modelOvf     = 1'b0;
    bit         modelUdf     = 1'b0;
    bit         readAccepted = 1'b0;
    int         preSize;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit w, input bit r, input logic [7:0] d, input bit c);
        winc  = w;
        rinc  = r;
        wdata = d;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".countF"}, 32'(countF), 32'd0);
        checkOutput({tag, ".countR"}, 32'(countR), 32'd0);
        checkOutput({tag, ".remptyF"}, 32'(remptyF), 32'd1);
        checkOutput({tag, ".remptyR"}, 32'(remptyR), 32'd1);
        checkOutput({tag, ".wfullF"}, 32'(wfullF), 32'd0);
        checkOutput({tag, ".aeF"}, 32'(aeF), 32'd1);
        checkOutput({tag, ".afF"}, 32'(afF), 32'd0);
        checkOutput({tag, ".ovfF"}, 32'(ovfF), 32'd0);
        checkOutput({tag, ".udfR"}, 32'(udfR), 32'd0);
        checkOutput({tag, ".rdataR"}, 32'(rdataR), 32'd0);
    endtask

    // Reference model: plain queue semantics evaluated on the pre-edge occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            expRegQ.delete();
            lastRead     = 8'h00;
            modelOvf     = 1'b0;
            modelUdf     = 1'b0;
            readAccepted = 1'b0;
        end else if (clr) begin
            modelQ.delete();
            expRegQ.delete();
            lastRead     = 8'h00;
            modelOvf     = 1'b0;
            modelUdf     = 1'b0;
            readAccepted = 1'b0;
        end else begin
            preSize = modelQ.size();
            if (winc && preSize == DEPTH) modelOvf = 1'b1;
            if (rinc && preSize == 0) modelUdf = 1'b1;
            readAccepted = rinc && (preSize > 0);
            if (readAccepted) expRegQ.push_back(modelQ.pop_front());
            if (winc && preSize < DEPTH) modelQ.push_back(wdata);
        end
    end

    // Monitor: compares status every cycle and pops the registered-read scoreboard after each accepted read.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("countF", 32'(countF), 32'(modelQ.size()));
            checkOutput("countR", 32'(countR), 32'(modelQ.size()));
            checkOutput("wfull", 32'(wfullF), 32'(modelQ.size() == DEPTH));
            checkOutput("remptyR", 32'(remptyR), 32'(modelQ.size() == 0));
            checkOutput("almostFull", 32'(afF), 32'(modelQ.size() >= AFULL_TH));
            checkOutput("almostEmpty", 32'(aeR), 32'(modelQ.size() <= AEMPTY_TH));
            checkOutput("overflow", 32'(ovfF), 32'(modelOvf));
            checkOutput("underflowR", 32'(udfR), 32'(modelUdf));
            if (modelQ.size() > 0) begin
                checkOutput("fwftHead", 32'(rdataF), 32'(modelQ[0]));
            end
            if (readAccepted) begin
                if (expRegQ.size() == 0) begin
                    checkOutput("regReadQueued", 32'd0, 32'd1);
                end else begin
                    popped   = expRegQ.pop_front();
                    lastRead = popped;
                    checkOutput("regRead", 32'(rdataR), 32'(popped));
                end
            end else begin
                checkOutput("regHold", 32'(rdataR), 32'(lastRead));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;

        // Fill with 0x00..0x0F, then one dropped write.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
        checkOutput("fullAfter16", 32'(wfullF), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
        checkOutput("countAfterDrop", 32'(countF), 32'd16);
        checkOutput("overflowSet", 32'(ovfR), 32'd1);

        // Drain, then read once more while empty.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("emptyAfter16", 32'(remptyF), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("underflowSet", 32'(udfF), 32'd1);
        checkOutput("countAfterUnderflow", 32'(countR), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Registered-read latency and hold.
        applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("regFirst", 32'(rdataR), 32'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("regHoldIdle", 32'(rdataR), 32'h5A);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("regSecond", 32'(rdataR), 32'h3C);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("regHoldUnderflow", 32'(rdataR), 32'h3C);
        checkOutput("regUnderflow", 32'(udfR), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Steady occupancy of 5 across two pointer wraps.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'(8'h85 + i), 1'b0);
        checkOutput("steadyCount", 32'(countF), 32'd5);

        // Flush at occupancy 9 with overflow set and both requests active.
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("preFlushCount", 32'(countF), 32'd9);
        checkOutput("preFlushOvf", 32'(ovfF), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1);
        checkOutput("flushCount", 32'(countR), 32'd0);
        checkOutput("flushOvf", 32'(ovfF), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0);
        checkOutput("postFlushHead", 32'(rdataF), 32'h77);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("postFlushRead", 32'(rdataR), 32'h77);

        // Randomised traffic, first biased toward filling, then toward draining.
        for (int i = 0; i < 250; i++) begin
            applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 35,
                          8'($urandom), $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 250; i++) begin
            applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
                          8'($urandom), $urandom_range(0, 99) == 0);
        end

        // Asynchronous reset in the middle of a write burst at occupancy 7.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        winc  = 1'b1;
        wdata = 8'h47;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("asyncReset");
        winc = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
        checkOutput("afterResetHead", 32'(rdataF), 32'h11);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("afterResetRead", 32'(rdataR), 32'h11);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
